// File: rtl/fb_pixel_writer.sv
// Write-side agent for the 640x480 framebuffer: converts (x, y) pixel writes into
// linear RAM writes (addr = x + H_RES*y + ADDR_BASE) and runs full-screen clear sweeps.
module fb_pixel_writer #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int ADDR_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [9:0]        px_x,
  input  logic [9:0]        px_y,
  input  logic [DATA_W-1:0] px_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              busy,
  output logic              clr_done,
  output logic              err_oob,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [10:0]       H_LIM      = 11'(H_RES);
  localparam logic [10:0]       V_LIM      = 11'(V_RES);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ADDR_BASE + H_RES * V_RES - 1);

  state_t              state, state_nxt;
  logic                we_nxt, busy_nxt, done_nxt, oob_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;

  logic                in_range;
  logic [ADDR_W-1:0]   x_ext, y_ext, row_off, pix_addr;

  // Every term is widened to ADDR_W before shifting so the row offset never truncates.
  assign x_ext = ADDR_W'(px_x);
  assign y_ext = ADDR_W'(px_y);

  generate
    if (H_RES == 640) begin : g_row_shift
      assign row_off = (y_ext << 9) + (y_ext << 7);
    end else begin : g_row_mul
      assign row_off = ADDR_W'(H_RES) * y_ext;
    end
  endgenerate

  assign pix_addr = x_ext + row_off + FIRST_ADDR;
  assign in_range = ({1'b0, px_x} < H_LIM) && ({1'b0, px_y} < V_LIM);

  // A clear request pre-empts a simultaneous pixel, so the pixel is held off this cycle.
  assign px_ready = (state == ST_IDLE) && !clr_start;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    we_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    oob_nxt   = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;

    unique case (state)
      ST_IDLE: begin
        if (clr_start) begin
          // mem_wdata doubles as the latched fill value for the whole sweep.
          state_nxt = ST_CLEAR;
          we_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          addr_nxt  = FIRST_ADDR;
          wdata_nxt = clr_data;
        end else if (px_valid) begin
          if (in_range) begin
            we_nxt    = 1'b1;
            addr_nxt  = pix_addr;
            wdata_nxt = px_data;
          end else begin
            oob_nxt = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        // mem_addr is the sweep counter; the end is detected by compare, not by wrap.
        if (mem_addr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          we_nxt   = 1'b1;
          busy_nxt = 1'b1;
          addr_nxt = mem_addr + 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      busy      <= busy_nxt;
      clr_done  <= done_nxt;
      err_oob   <= oob_nxt;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: table-driven pixel vectors plus hand-written
// sequences for the clear sweep, clear/pixel interaction and asynchronous reset.
module tb_fb_pixel_writer;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int NPIX   = 640 * 480;

  logic              clk = 1'b0;
  logic              rst;
  logic              px_valid;
  logic              px_ready;
  logic [9:0]        px_x, px_y;
  logic [DATA_W-1:0] px_data;
  logic              clr_start;
  logic [DATA_W-1:0] clr_data;
  logic              busy, clr_done, err_oob, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  fb_pixel_writer dut (
    .clk       (clk),
    .rst       (rst),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_data   (px_data),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .busy      (busy),
    .clr_done  (clr_done),
    .err_oob   (err_oob),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [DATA_W-1:0] data;
    logic              exp_we;
    logic              exp_oob;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input logic v, input logic [9:0] x, input logic [9:0] y,
                          input logic [DATA_W-1:0] d);
    px_valid = v;
    px_x     = x;
    px_y     = y;
    px_data  = d;
  endtask

  vec_t vecs[12];

  initial begin
    int sweep_bad;
    int first_bad;

    // Address/data expectations are hand-computed from x + 640*y + 1; out-of-range
    // and idle vectors expect the previous address/data to be held.
    vecs[0]  = '{1'b1, 10'd0,   10'd0,   8'hAA, 1'b1, 1'b0, 19'd1,      8'hAA};
    vecs[1]  = '{1'b0, 10'd0,   10'd0,   8'h00, 1'b0, 1'b0, 19'd1,      8'hAA};
    vecs[2]  = '{1'b1, 10'd639, 10'd479, 8'h3C, 1'b1, 1'b0, 19'd307200, 8'h3C};
    vecs[3]  = '{1'b1, 10'd5,   10'd2,   8'h11, 1'b1, 1'b0, 19'd1286,   8'h11};
    vecs[4]  = '{1'b1, 10'd640, 10'd0,   8'hEE, 1'b0, 1'b1, 19'd1286,   8'h11};
    vecs[5]  = '{1'b1, 10'd0,   10'd480, 8'hDD, 1'b0, 1'b1, 19'd1286,   8'h11};
    vecs[6]  = '{1'b1, 10'd1,   10'd0,   8'h01, 1'b1, 1'b0, 19'd2,      8'h01};
    vecs[7]  = '{1'b1, 10'd2,   10'd0,   8'h02, 1'b1, 1'b0, 19'd3,      8'h02};
    vecs[8]  = '{1'b1, 10'd3,   10'd0,   8'h03, 1'b1, 1'b0, 19'd4,      8'h03};
    vecs[9]  = '{1'b1, 10'd639, 10'd0,   8'h44, 1'b1, 1'b0, 19'd640,    8'h44};
    vecs[10] = '{1'b1, 10'd0,   10'd1,   8'h45, 1'b1, 1'b0, 19'd641,    8'h45};
    vecs[11] = '{1'b0, 10'd0,   10'd0,   8'h00, 1'b0, 1'b0, 19'd641,    8'h45};

    rst       = 1'b1;
    clr_start = 1'b0;
    clr_data  = '0;
    drive_px(1'b0, '0, '0, '0);
    tick();
    tick();

    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(clr_done),  32'd0);
    check("rst_oob",   32'(err_oob),   32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive_px(vecs[i].valid, vecs[i].x, vecs[i].y, vecs[i].data);
      #1;
      check($sformatf("v%0d_ready", i), 32'(px_ready), 32'd1);
      tick();
      check($sformatf("v%0d_we", i),    32'(mem_we),    32'(vecs[i].exp_we));
      check($sformatf("v%0d_oob", i),   32'(err_oob),   32'(vecs[i].exp_oob));
      check($sformatf("v%0d_addr", i),  32'(mem_addr),  32'(vecs[i].exp_addr));
      check($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].exp_wdata));
    end

    // Full clear with a pixel request held throughout; clear must win the first cycle.
    drive_px(1'b1, 10'd10, 10'd0, 8'h55);
    clr_start = 1'b1;
    clr_data  = 8'h07;
    #1;
    check("clr_prio_ready", 32'(px_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    clr_data  = 8'hFF;
    sweep_bad = 0;
    first_bad = -1;
    for (int i = 0; i < NPIX; i++) begin
      if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i + 1) || mem_wdata !== 8'h07 ||
          busy !== 1'b1 || clr_done !== 1'b0 || err_oob !== 1'b0 || px_ready !== 1'b0) begin
        sweep_bad++;
        if (first_bad < 0) first_bad = i;
      end
      clr_start = (i == 500);
      tick();
    end
    clr_start = 1'b0;
    check("sweep_bad_cycles", 32'(sweep_bad), 32'd0);
    if (first_bad >= 0) $display("  first bad sweep write index %0d", first_bad);
    check("end_done",  32'(clr_done), 32'd1);
    check("end_busy",  32'(busy),     32'd0);
    check("end_we",    32'(mem_we),   32'd0);
    check("end_ready", 32'(px_ready), 32'd1);
    tick();
    check("held_px_we",    32'(mem_we),    32'd1);
    check("held_px_addr",  32'(mem_addr),  32'd11);
    check("held_px_wdata", 32'(mem_wdata), 32'h55);
    check("done_pulse",    32'(clr_done),  32'd0);
    drive_px(1'b0, '0, '0, '0);
    tick();
    check("post_we", 32'(mem_we), 32'd0);

    // Pixel in cycle N-1 then clr_start in cycle N: pixel write first, then clear.
    drive_px(1'b1, 10'd7, 10'd0, 8'h22);
    tick();
    drive_px(1'b0, '0, '0, '0);
    clr_start = 1'b1;
    clr_data  = 8'h09;
    #1;
    check("pc_px_we",   32'(mem_we),   32'd1);
    check("pc_px_addr", 32'(mem_addr), 32'd8);
    check("pc_px_busy", 32'(busy),     32'd0);
    tick();
    clr_start = 1'b0;
    check("pc_clr_addr",  32'(mem_addr),  32'd1);
    check("pc_clr_wdata", 32'(mem_wdata), 32'h09);
    check("pc_clr_busy",  32'(busy),      32'd1);
    for (int i = 0; i < 999; i++) tick();
    check("pre_rst_addr", 32'(mem_addr), 32'd1000);
    check("pre_rst_we",   32'(mem_we),   32'd1);

    // Asynchronous reset mid-cycle abandons the sweep.
    #2;
    rst = 1'b1;
    #1;
    check("arst_we",    32'(mem_we),    32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_addr",  32'(mem_addr),  32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    check("arst_done",  32'(clr_done),  32'd0);
    tick();
    rst = 1'b0;
    sweep_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (clr_done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) sweep_bad++;
    end
    check("arst_quiet", 32'(sweep_bad), 32'd0);
    drive_px(1'b1, 10'd5, 10'd2, 8'h11);
    tick();
    drive_px(1'b0, '0, '0, '0);
    check("arst_px_we",    32'(mem_we),    32'd1);
    check("arst_px_addr",  32'(mem_addr),  32'd1286);
    check("arst_px_wdata", 32'(mem_wdata), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side agent for the 640x480 VGA framebuffer.
- Accepts single-pixel writes in (x, y) coordinates from the CPU/rasteriser side over a valid/ready handshake and converts them to linear framebuffer addresses.
- Uses the same address map as the VGA read path: addr = x + 640*y + 1.
- Also provides a hardware full-screen clear sweep. Drives the framebuffer RAM write port directly.

Parameters:
- H_RES, 640, horizontal pixels per line.
- V_RES, 480, visible lines.
- ADDR_W, 19, framebuffer address width.
- DATA_W, 8, pixel data width.
- ADDR_BASE, 1, address offset added to every linear address.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- px_valid  input  1  pixel write request.
- px_ready  output  1  pixel write accepted this cycle when high together with px_valid.
- px_x  input  10  pixel column.
- px_y  input  10  pixel row.
- px_data  input  DATA_W  pixel value.
- clr_start  input  1  start a full-screen clear (single-cycle pulse, level also accepted).
- clr_data  input  DATA_W  fill value, sampled in the clr_start cycle.
- busy  output  1  clear sweep in progress.
- clr_done  output  1  one-cycle pulse when the sweep completes.
- err_oob  output  1  one-cycle pulse when an accepted pixel was out of range.
- mem_we  output  1  framebuffer write enable.
- mem_addr  output  ADDR_W  framebuffer write address.
- mem_wdata  output  DATA_W  framebuffer write data.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all registered outputs 0 (mem_we, mem_addr, mem_wdata, busy, clr_done, err_oob). A reset mid-sweep abandons the sweep with no clr_done.
- States: IDLE and CLEAR.
- px_ready = (state == IDLE) && !clr_start. This is combinational, and clear has priority over a simultaneous pixel.
- Pixel path, accepted in cycle N:
  - In range (px_x < H_RES and px_y < V_RES): in cycle N+1, mem_we = 1, mem_addr = px_x + H_RES*px_y + ADDR_BASE, mem_wdata = px_data.
  - Latency is 1 cycle and throughput is 1 pixel per cycle; back-to-back accepts produce back-to-back writes.
  - Out of range: in cycle N+1, mem_we = 0 and err_oob = 1. Addr and data registers hold their previous values.
- No accept in cycle N: mem_we = 0 in cycle N+1 (unless CLEAR is active).
- Arithmetic:
  - Compute H_RES*px_y as (px_y<<9)+(px_y<<7) for the default values.
  - Carry all terms at ADDR_W bits with no truncation.
  - Maximum address is 307200 (< 2^19).
- IDLE to CLEAR: on clr_start in IDLE (cycle N):
  - Latch clr_data.
  - From cycle N+1, busy = 1 and mem_we = 1 every cycle.
  - mem_addr steps ADDR_BASE, ADDR_BASE+1, ..., ADDR_BASE + H_RES*V_RES - 1 (1..307200), with mem_wdata = the latched fill value.
  - Total of exactly 307200 write cycles.
- Pixel accepted in cycle N-1 followed by clr_start in cycle N: the pixel write appears in cycle N and the first clear write in cycle N+1, so there is no collision.
- CLEAR to IDLE: the cycle after the last clear write (address 307200) has:
  - busy = 0, mem_we = 0, clr_done = 1, state IDLE.
  - px_ready may be 1 in that same cycle.
- During CLEAR:
  - px_ready = 0; px_valid is stalled, not dropped.
  - clr_start is ignored and does not restart or extend the sweep.
- Sweep counter: ADDR_W bits, compared against the final address (no reliance on wrap).
- err_oob and clr_done are never high for more than one cycle per event.

Test Plan:
- Reset then pixel (0,0,0xAA) -> next cycle mem_we=1, mem_addr=1, mem_wdata=0xAA; following cycle mem_we=0.
- Pixel (639,479,0x3C) -> mem_addr=307200; pixel (5,2,0x11) -> mem_addr=1286.
- Pixels (640,0) and (0,480) -> mem_we stays 0, err_oob pulses once per request, px_ready stays 1.
- Three back-to-back pixels (1,0),(2,0),(3,0) -> three consecutive writes at addresses 2,3,4.
- clr_start with clr_data=0x07 -> exactly 307200 consecutive writes, addresses 1..307200, data 0x07, busy high throughout, clr_done one-cycle pulse in the following cycle. A px_valid held during the sweep is accepted only after clr_done, and a second clr_start mid-sweep has no effect.
- Reset asserted asynchronously at sweep write 1000 -> mem_we, busy and all outputs 0 immediately, no clr_done; after release a new pixel writes normally.
